// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 8x8 register file: two one-entry request buffers (ALU, MEM)
// share the single registered write port, oldest request first, with a pending-register mask.
module regfile_wb_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 ALU_VALID,
   input  logic [ADDR_W-1:0]    ALU_ADDR,
   input  logic [DATA_W-1:0]    ALU_DATA,
   output logic                 ALU_READY,
   input  logic                 MEM_VALID,
   input  logic [ADDR_W-1:0]    MEM_ADDR,
   input  logic [DATA_W-1:0]    MEM_DATA,
   output logic                 MEM_READY,
   output logic                 WRITE,
   output logic [ADDR_W-1:0]    INADDRESS,
   output logic [DATA_W-1:0]    IN,
   output logic                 ISSUED_SRC,
   output logic [2**ADDR_W-1:0] PENDING
);

   logic              r_alu_full;
   logic [ADDR_W-1:0] r_alu_addr;
   logic [DATA_W-1:0] r_alu_data;
   logic              r_mem_full;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_alu_older;
   logic              r_mem_older;
   logic              r_tie_mem;
   logic              r_write;
   logic [ADDR_W-1:0] r_inaddr;
   logic [DATA_W-1:0] r_in;
   logic              r_src;

   logic w_grant_alu;
   logic w_grant_mem;
   logic w_tie;
   logic w_alu_load;
   logic w_mem_load;
   logic w_alu_stay;
   logic w_mem_stay;

   // Neither age flag set while both are full means both were loaded on the same edge.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_grant_alu = 1'b0;
      w_grant_mem = 1'b0;
      w_tie       = 1'b0;
      if (r_alu_full && r_mem_full) begin
         if (r_alu_older) begin
            w_grant_alu = 1'b1;
         end else if (r_mem_older) begin
            w_grant_mem = 1'b1;
         end else begin
            w_tie       = 1'b1;
            w_grant_mem = r_tie_mem;
            w_grant_alu = ~r_tie_mem;
         end
      end else if (r_alu_full) begin
         w_grant_alu = 1'b1;
      end else if (r_mem_full) begin
         w_grant_mem = 1'b1;
      end
   end

   assign ALU_READY  = ~r_alu_full | w_grant_alu;
   assign MEM_READY  = ~r_mem_full | w_grant_mem;
   assign w_alu_load = ALU_VALID & ALU_READY;
   assign w_mem_load = MEM_VALID & MEM_READY;
   assign w_alu_stay = r_alu_full & ~w_grant_alu;
   assign w_mem_stay = r_mem_full & ~w_grant_mem;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_alu_full  <= 1'b0;
         r_mem_full  <= 1'b0;
         r_alu_older <= 1'b0;
         r_mem_older <= 1'b0;
         r_tie_mem   <= 1'b0;
         r_write     <= 1'b0;
         r_inaddr    <= '0;
         r_in        <= '0;
         r_src       <= 1'b0;
      end else begin
         r_alu_full  <= w_alu_load | w_alu_stay;
         r_mem_full  <= w_mem_load | w_mem_stay;
         // A surviving entry is older than anything loaded alongside it.
         r_alu_older <= w_alu_stay & (w_mem_load | (w_mem_stay & r_alu_older));
         r_mem_older <= w_mem_stay & (w_alu_load | (w_alu_stay & r_mem_older));
         if (w_tie) begin
            r_tie_mem <= ~r_tie_mem;
         end
         r_write <= w_grant_alu | w_grant_mem;
         if (w_grant_alu || w_grant_mem) begin
            r_inaddr <= w_grant_mem ? r_mem_addr : r_alu_addr;
            r_in     <= w_grant_mem ? r_mem_data : r_alu_data;
            r_src    <= w_grant_mem;
         end
      end
   end

   // NOTE: buffer payload is not reset; it is only observed while its full flag is set.
   always_ff @(posedge CLK) begin
      if (w_alu_load) begin
         r_alu_addr <= ALU_ADDR;
         r_alu_data <= ALU_DATA;
      end
      if (w_mem_load) begin
         r_mem_addr <= MEM_ADDR;
         r_mem_data <= MEM_DATA;
      end
   end

   assign WRITE      = r_write;
   assign INADDRESS  = r_inaddr;
   assign IN         = r_in;
   assign ISSUED_SRC = r_src;

   always_comb begin
      PENDING = '0;
      if (r_alu_full) PENDING[r_alu_addr] = 1'b1;
      if (r_mem_full) PENDING[r_mem_addr] = 1'b1;
      if (r_write)    PENDING[r_inaddr]   = 1'b1;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: accepted requests are queued in expected issue
// order and compared against every WRITE pulse; a behavioural reg file checks final contents.
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic       src;
      logic [2:0] addr;
      logic [7:0] data;
   } wb_t;

   logic       CLK;
   logic       RESET;
   logic       ALU_VALID;
   logic [2:0] ALU_ADDR;
   logic [7:0] ALU_DATA;
   logic       ALU_READY;
   logic       MEM_VALID;
   logic [2:0] MEM_ADDR;
   logic [7:0] MEM_DATA;
   logic       MEM_READY;
   logic       WRITE;
   logic [2:0] INADDRESS;
   logic [7:0] IN;
   logic       ISSUED_SRC;
   logic [7:0] PENDING;

   logic [7:0] rf [8];
   wb_t        sb [$];
   logic       tb_tie_mem;
   int         checks;
   int         errors;

   regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
      .CLK(CLK), .RESET(RESET),
      .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
      .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
      .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .ISSUED_SRC(ISSUED_SRC), .PENDING(PENDING)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Register file model driven only by the DUT's write port.
   always @(posedge CLK) begin
      if (WRITE === 1'b1) rf[INADDRESS] <= IN;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic src, input logic [2:0] addr, input logic [7:0] data);
      wb_t e;
      e.src  = src;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
   endtask

   // Drive at the negedge, then record what the coming edge will accept, in expected issue order.
   task automatic step(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [7:0] md);
      logic a_go, m_go;
      @(negedge CLK);
      ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
      MEM_VALID = mv; MEM_ADDR = ma; MEM_DATA = md;
      #1;
      a_go = av && ALU_READY && !RESET;
      m_go = mv && MEM_READY && !RESET;
      if (a_go && m_go) begin
         if (tb_tie_mem) begin
            push(1'b1, ma, md);
            push(1'b0, aa, ad);
         end else begin
            push(1'b0, aa, ad);
            push(1'b1, ma, md);
         end
         tb_tie_mem = ~tb_tie_mem;
      end else if (a_go) begin
         push(1'b0, aa, ad);
      end else if (m_go) begin
         push(1'b1, ma, md);
      end
   endtask

   task automatic idle_step();
      step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
   endtask

   // Scoreboard: every WRITE pulse must match the oldest outstanding accepted request.
   initial begin
      wb_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (WRITE === 1'b1) begin
            if (sb.size() == 0) begin
               check("wr_unexpected", 32'(WRITE), 32'd0);
            end else begin
               e = sb.pop_front();
               check("wr_addr", 32'(INADDRESS), 32'(e.addr));
               check("wr_data", 32'(IN), 32'(e.data));
               check("wr_src", 32'(ISSUED_SRC), 32'(e.src));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      tb_tie_mem = 1'b0;
      RESET = 1'b1;
      ALU_VALID = 1'b1; ALU_ADDR = 3'd2; ALU_DATA = 8'h1F;
      MEM_VALID = 1'b0; MEM_ADDR = 3'd0; MEM_DATA = 8'h00;

      // Reset held with a live ALU request
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check("rst_write", 32'(WRITE), 32'd0);
         check("rst_pending", 32'(PENDING), 32'h00);
         check("rst_alu_ready", 32'(ALU_READY), 32'd1);
         check("rst_mem_ready", 32'(MEM_READY), 32'd1);
      end
      RESET = 1'b0;
      ALU_VALID = 1'b0;
      step(1'b1, 3'd2, 8'h1F, 1'b0, 3'd0, 8'h00);
      repeat (3) idle_step();
      check("rst_rf2", 32'(rf[2]), 32'h1F);

      // Single ALU write
      step(1'b1, 3'd4, 8'h55, 1'b0, 3'd0, 8'h00);
      idle_step();
      check("single_pend0", 32'(PENDING), 32'h10);
      check("single_wr0", 32'(WRITE), 32'd0);
      idle_step();
      check("single_pend1", 32'(PENDING), 32'h10);
      check("single_wr1", 32'(WRITE), 32'd1);
      idle_step();
      check("single_pend2", 32'(PENDING), 32'h00);
      check("single_wr2", 32'(WRITE), 32'd0);
      check("single_rf4", 32'(rf[4]), 32'h55);

      // Simultaneous load: ALU first, then repeated with MEM first
      for (int r = 0; r < 2; r++) begin
         step(1'b1, 3'd1, 8'hAA, 1'b1, 3'd3, 8'h0F);
         idle_step();
         check("sim_pend0", 32'(PENDING), 32'h0A);
         idle_step();
         check("sim_pend1", 32'(PENDING), 32'h0A);
         idle_step();
         check("sim_pend2", 32'(PENDING), (r == 0) ? 32'h08 : 32'h02);
         idle_step();
         check("sim_pend3", 32'(PENDING), 32'h00);
      end

      // Age: MEM then ALU on consecutive edges, same register
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h01);
      step(1'b1, 3'd2, 8'h02, 1'b0, 3'd0, 8'h00);
      repeat (3) idle_step();
      check("age_a_rf2", 32'(rf[2]), 32'h02);

      // Age: ALU reloads on its tie-grant edge while MEM survives, so MEM issues first
      step(1'b1, 3'd5, 8'h33, 1'b1, 3'd2, 8'h01);
      step(1'b1, 3'd2, 8'h02, 1'b0, 3'd0, 8'h00);
      check("age_b_pend", 32'(PENDING), 32'h24);
      repeat (4) idle_step();
      check("age_b_rf2", 32'(rf[2]), 32'h02);
      check("age_b_rf5", 32'(rf[5]), 32'h33);

      // Back-to-back streaming
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 3'd0, 8'h00);
         check("stream_ready", 32'(ALU_READY), 32'd1);
         if (i >= 2) check("stream_wr", 32'(WRITE), 32'd1);
      end
      idle_step();
      check("stream_wr6", 32'(WRITE), 32'd1);
      idle_step();
      check("stream_wr7", 32'(WRITE), 32'd1);
      idle_step();
      check("stream_wr_end", 32'(WRITE), 32'd0);
      for (int i = 0; i < 8; i++) check("stream_rf", 32'(rf[i]), 32'(8'h10 + i));

      // Reset while both buffers are full
      step(1'b1, 3'd6, 8'hEE, 1'b1, 3'd7, 8'hDD);
      idle_step();
      check("mrst_pend_before", 32'(PENDING), 32'hC0);
      RESET = 1'b1;
      sb.delete();
      tb_tie_mem = 1'b0;
      @(negedge CLK);
      check("mrst_wr", 32'(WRITE), 32'd0);
      check("mrst_pend", 32'(PENDING), 32'h00);
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle_step();
         check("mrst_wr_after", 32'(WRITE), 32'd0);
         check("mrst_pend_after", 32'(PENDING), 32'h00);
      end
      check("mrst_rf6", 32'(rf[6]), 32'h16);
      check("mrst_rf7", 32'(rf[7]), 32'h17);

      // Tie pointer back to ALU-first after reset
      step(1'b1, 3'd1, 8'h5A, 1'b1, 3'd3, 8'hA5);
      idle_step();
      idle_step();
      check("ptr_rst_src", 32'(ISSUED_SRC), 32'd0);
      repeat (3) idle_step();
      check("ptr_rst_rf1", 32'(rf[1]), 32'h5A);
      check("ptr_rst_rf3", 32'(rf[3]), 32'hA5);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
